// File: rtl/floo_pkg.sv
// Shared types and helpers for the flit-level NoC credit logic.
package floo_pkg;

  localparam int unsigned NumVCWidthMax = 8;

  typedef logic [NumVCWidthMax-1:0] vc_id_t;

  // Credit return message carried on the link back from downstream.
  typedef struct packed {
    logic   valid;
    vc_id_t vc_id;
  } credit_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/floo_credit_cnt_single.sv
// Saturating up/down credit counter for a single VC; flags per-cycle
// underflow/overflow events, leaving stickiness to the caller.
module floo_credit_cnt_single #(
  parameter int unsigned          CntWidth = 3,
  parameter logic [CntWidth-1:0]  MaxVal   = '1,
  parameter logic [CntWidth-1:0]  ResetVal = MaxVal
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                underflow_o,
  output logic                overflow_o
);

  logic [CntWidth-1:0] cnt_d, cnt_q;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    // Simultaneous inc and dec cancel, even at 0 or max.
    if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else             underflow_o = 1'b1;
    end else if (inc_i && !dec_i) begin
      if (cnt_q < MaxVal) cnt_d = cnt_q + 1'b1;
      else                overflow_o = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= ResetVal;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/floo_vc_credit_counter.sv
// Per-VC credit tracking for one router output: decodes consume/credit ids,
// runs one saturating counter per VC and keeps sticky error flags.
module floo_vc_credit_counter
  import floo_pkg::*;
#(
  parameter int unsigned NumVC           = 4,
  parameter int unsigned NumVCWidth      = idx_width(NumVC),
  parameter int unsigned VCDepth         = 2,
  parameter int unsigned DeeperVCId      = 0,
  parameter int unsigned DeeperVCDepth   = 4,
  parameter int unsigned CntWidth        = $clog2(DeeperVCDepth + 1),
  parameter bit          EnableErrAssert = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        consume_valid_i,
  input  logic [NumVCWidth-1:0]       consume_id_i,
  input  logic                        credit_valid_i,
  input  logic [NumVCWidth-1:0]       credit_id_i,
  output logic [NumVC-1:0]            vc_not_full_o,
  output logic [NumVC*CntWidth-1:0]   vc_credit_o,
  output logic                        err_underflow_o,
  output logic                        err_overflow_o
);

  function automatic logic [CntWidth-1:0] vc_max(input int unsigned v);
    return (v == DeeperVCId) ? CntWidth'(DeeperVCDepth) : CntWidth'(VCDepth);
  endfunction

  vc_id_t consume_id, credit_id;
  assign consume_id = vc_id_t'(consume_id_i);
  assign credit_id  = vc_id_t'(credit_id_i);

  logic [NumVC-1:0] dec, inc, uf_ev, of_ev;

  for (genvar v = 0; v < NumVC; v++) begin : g_vc
    logic [CntWidth-1:0] cnt;

    assign dec[v] = consume_valid_i && (consume_id == vc_id_t'(v));
    assign inc[v] = credit_valid_i  && (credit_id  == vc_id_t'(v));

    floo_credit_cnt_single #(
      .CntWidth (CntWidth),
      .MaxVal   (vc_max(v)),
      .ResetVal (vc_max(v))
    ) i_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inc_i       (inc[v]),
      .dec_i       (dec[v]),
      .cnt_o       (cnt),
      .underflow_o (uf_ev[v]),
      .overflow_o  (of_ev[v])
    );

    assign vc_not_full_o[v]                   = (cnt != '0);
    assign vc_credit_o[v*CntWidth +: CntWidth] = cnt;
  end

  // An id that matched no VC is out of range and counts as an error event.
  logic consume_oor, credit_oor;
  assign consume_oor = consume_valid_i && !(|dec);
  assign credit_oor  = credit_valid_i  && !(|inc);

  logic err_underflow_d, err_underflow_q;
  logic err_overflow_d,  err_overflow_q;

  always_comb begin
    err_underflow_d = err_underflow_q | (|uf_ev) | consume_oor;
    err_overflow_d  = err_overflow_q  | (|of_ev) | credit_oor;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign err_underflow_o = err_underflow_q;
  assign err_overflow_o  = err_overflow_q;

`ifndef SYNTHESIS
  a_depth_order: assert property (@(posedge clk_i) DeeperVCDepth >= VCDepth);
  a_deeper_id:   assert property (@(posedge clk_i) DeeperVCId < NumVC);

  if (EnableErrAssert) begin : g_err_assert
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !((|uf_ev) || consume_oor));
    a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !((|of_ev) || credit_oor));
  end
`endif

endmodule
